// File: rtl/write_resp_router.sv
// Write-response return path for the two-master interconnect.
// Keeps the owner of every accepted AW in acceptance order and routes each
// slave B response back to that owner through a one-entry output register.
module write_resp_router #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             aw_push,
    input  logic             aw_master,
    output logic             aw_stall,
    output logic [CNT_W-1:0] outstanding,
    input  logic             M_AXI_bvalid,
    input  logic [1:0]       M_AXI_bresp,
    output logic             M_AXI_bready,
    output logic             S00_AXI_bvalid,
    output logic [1:0]       S00_AXI_bresp,
    input  logic             S00_AXI_bready,
    output logic             S01_AXI_bvalid,
    output logic [1:0]       S01_AXI_bresp,
    input  logic             S01_AXI_bready,
    output logic             err_unexpected,
    output logic             err_overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] fifo_q, fifo_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic             out_sel_q, out_sel_d;
    logic [1:0]       out_resp_q, out_resp_d;
    logic             err_unexp_q, err_unexp_d;
    logic             err_ovf_q, err_ovf_d;

    logic full, empty, push, pop, out_accept;

    // Handshake qualifiers; slave ready is held off while the output register is busy.
    always_comb begin
        full         = (count_q == CNT_W'(DEPTH));
        empty        = (count_q == '0);
        out_accept   = out_valid_q && (out_sel_q ? S01_AXI_bready : S00_AXI_bready);
        M_AXI_bready = !empty && (!out_valid_q || out_accept);
        pop          = M_AXI_bvalid && M_AXI_bready;
        push         = aw_push && !full;
    end

    // Next state for the order FIFO, output register and sticky error flags.
    always_comb begin
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_sel_d   = out_sel_q;
        out_resp_d  = out_resp_q;
        err_unexp_d = err_unexp_q || (M_AXI_bvalid && empty);
        err_ovf_d   = err_ovf_q || (aw_push && full);

        if (push) begin
            fifo_d[wr_ptr_q] = aw_master;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (pop) begin
            out_valid_d = 1'b1;
            out_sel_d   = fifo_q[rd_ptr_q];
            out_resp_d  = M_AXI_bresp;
        end else if (out_accept) begin
            out_valid_d = 1'b0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            fifo_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_sel_q   <= 1'b0;
            out_resp_q  <= 2'b00;
            err_unexp_q <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            out_resp_q  <= out_resp_d;
            err_unexp_q <= err_unexp_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    // Steering toward the masters; only the owner ever sees bvalid.
    always_comb begin
        aw_stall       = full;
        outstanding    = count_q;
        S00_AXI_bvalid = out_valid_q && !out_sel_q;
        S01_AXI_bvalid = out_valid_q && out_sel_q;
        S00_AXI_bresp  = out_resp_q;
        S01_AXI_bresp  = out_resp_q;
        err_unexpected = err_unexp_q;
        err_overflow   = err_ovf_q;
    end

endmodule

// File: tb/tb_write_resp_router.sv
// Bench for write_resp_router: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_write_resp_router;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             ACLK = 1'b0;
    logic             ARESET;
    logic             aw_push, aw_master;
    logic             aw_stall;
    logic [CNT_W-1:0] outstanding;
    logic             M_AXI_bvalid;
    logic [1:0]       M_AXI_bresp;
    logic             M_AXI_bready;
    logic             S00_AXI_bvalid, S01_AXI_bvalid;
    logic [1:0]       S00_AXI_bresp, S01_AXI_bresp;
    logic             S00_AXI_bready, S01_AXI_bready;
    logic             err_unexpected, err_overflow;

    int checks = 0;
    int errors = 0;

    write_resp_router #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .aw_push(aw_push), .aw_master(aw_master),
        .aw_stall(aw_stall), .outstanding(outstanding),
        .M_AXI_bvalid(M_AXI_bvalid), .M_AXI_bresp(M_AXI_bresp), .M_AXI_bready(M_AXI_bready),
        .S00_AXI_bvalid(S00_AXI_bvalid), .S00_AXI_bresp(S00_AXI_bresp), .S00_AXI_bready(S00_AXI_bready),
        .S01_AXI_bvalid(S01_AXI_bvalid), .S01_AXI_bresp(S01_AXI_bresp), .S01_AXI_bready(S01_AXI_bready),
        .err_unexpected(err_unexpected), .err_overflow(err_overflow)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: a queue of owners plus the response waiting at the masters.
    bit       q[$];
    bit       m_ok = 0;
    bit       h_valid, h_sel;
    bit [1:0] h_resp;
    bit       m_eu, m_eo;

    always @(negedge ACLK) begin
        bit m_full, m_empty, m_acc, m_rdy, head;
        m_full  = (q.size() == DEPTH);
        m_empty = (q.size() == 0);
        m_acc   = h_valid && (h_sel ? S01_AXI_bready : S00_AXI_bready);
        m_rdy   = !m_empty && (!h_valid || m_acc);
        if (m_ok) begin
            chk("m_bready", M_AXI_bready, m_rdy);
            chk("aw_stall", aw_stall, m_full);
            chk("outstanding", outstanding, q.size());
            chk("s00_bvalid", S00_AXI_bvalid, h_valid && !h_sel);
            chk("s01_bvalid", S01_AXI_bvalid, h_valid && h_sel);
            if (h_valid && !h_sel) chk("s00_bresp", S00_AXI_bresp, h_resp);
            if (h_valid && h_sel)  chk("s01_bresp", S01_AXI_bresp, h_resp);
            chk("err_unexpected", err_unexpected, m_eu);
            chk("err_overflow", err_overflow, m_eo);
        end
        if (ARESET) begin
            q.delete();
            h_valid = 0; h_sel = 0; h_resp = 0; m_eu = 0; m_eo = 0;
            m_ok = 1;
        end else if (m_ok) begin
            if (M_AXI_bvalid && m_empty) m_eu = 1;
            if (aw_push && m_full) m_eo = 1;
            if (M_AXI_bvalid && m_rdy) begin
                head = q.pop_front();
                h_valid = 1; h_sel = head; h_resp = M_AXI_bresp;
            end else if (m_acc) begin
                h_valid = 0;
            end
            if (aw_push && !m_full) q.push_back(aw_master);
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        bit done;
        ARESET = 1; aw_push = 0; aw_master = 0;
        M_AXI_bvalid = 0; M_AXI_bresp = 0;
        S00_AXI_bready = 1; S01_AXI_bready = 1;
        tick(); tick();
        ARESET = 0;
        chk("rst_outstanding", outstanding, 0);
        chk("rst_m_bready", M_AXI_bready, 0);
        chk("rst_aw_stall", aw_stall, 0);
        chk("rst_s00_bvalid", S00_AXI_bvalid, 0);

        // Single write to S00
        aw_push = 1; aw_master = 0; tick(); aw_push = 0;
        chk("single_out1", outstanding, 1);
        M_AXI_bvalid = 1; M_AXI_bresp = 2'b00; #1;
        chk("single_mrdy", M_AXI_bready, 1);
        tick(); M_AXI_bvalid = 0;
        chk("single_s00v", S00_AXI_bvalid, 1);
        chk("single_s00r", S00_AXI_bresp, 2'b00);
        chk("single_s01v", S01_AXI_bvalid, 0);
        chk("single_out0", outstanding, 0);
        tick();

        // Ordering 1,0,1 with back-to-back responses
        aw_push = 1; aw_master = 1; tick();
        aw_master = 0; tick();
        aw_master = 1; tick(); aw_push = 0;
        M_AXI_bvalid = 1; M_AXI_bresp = 2'b00; tick();
        chk("ord1_s01v", S01_AXI_bvalid, 1); chk("ord1_r", S01_AXI_bresp, 2'b00);
        M_AXI_bresp = 2'b10; tick();
        chk("ord2_s00v", S00_AXI_bvalid, 1); chk("ord2_r", S00_AXI_bresp, 2'b10);
        chk("ord2_s01v", S01_AXI_bvalid, 0);
        M_AXI_bresp = 2'b01; tick(); M_AXI_bvalid = 0;
        chk("ord3_s01v", S01_AXI_bvalid, 1); chk("ord3_r", S01_AXI_bresp, 2'b01);
        tick();
        chk("ord_idle", S00_AXI_bvalid | S01_AXI_bvalid, 0);

        // Fill, overflow, then free one entry
        for (int i = 0; i < 4; i++) begin
            aw_push = 1; aw_master = i[0]; tick();
        end
        chk("full_stall", aw_stall, 1);
        chk("full_out", outstanding, 4);
        tick(); aw_push = 0;
        chk("ovf_flag", err_overflow, 1);
        chk("ovf_out", outstanding, 4);
        M_AXI_bvalid = 1; M_AXI_bresp = 2'b11; tick(); M_AXI_bvalid = 0;
        chk("free_stall", aw_stall, 0);
        chk("free_out", outstanding, 3);
        M_AXI_bvalid = 1;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (outstanding == 0) done = 1;
        end
        M_AXI_bvalid = 0;
        chk("drain_done", done, 1);
        tick();

        // Response with nothing outstanding is stalled and flagged
        M_AXI_bvalid = 1; #1;
        chk("empty_mrdy", M_AXI_bready, 0);
        tick();
        chk("empty_err", err_unexpected, 1);
        chk("empty_sv", S00_AXI_bvalid | S01_AXI_bvalid, 0);
        M_AXI_bvalid = 0; tick();
        chk("empty_sticky", err_unexpected, 1);

        // Reset mid-operation with a held response
        aw_push = 1; aw_master = 0; tick(); tick(); tick(); aw_push = 0;
        S00_AXI_bready = 0; M_AXI_bvalid = 1; M_AXI_bresp = 2'b10; tick(); M_AXI_bvalid = 0;
        chk("mid_out", outstanding, 2);
        chk("mid_held", S00_AXI_bvalid, 1);
        tick(); tick();
        chk("mid_held_r", S00_AXI_bresp, 2'b10);
        ARESET = 1; tick(); ARESET = 0;
        chk("mrst_out", outstanding, 0);
        chk("mrst_s00v", S00_AXI_bvalid, 0);
        chk("mrst_eu", err_unexpected, 0);
        chk("mrst_eo", err_overflow, 0);
        S00_AXI_bready = 1;
        aw_push = 1; aw_master = 1; tick(); aw_push = 0;
        M_AXI_bvalid = 1; M_AXI_bresp = 2'b11; tick(); M_AXI_bvalid = 0;
        chk("fresh_s01v", S01_AXI_bvalid, 1);
        chk("fresh_r", S01_AXI_bresp, 2'b11);
        tick();

        // Randomized traffic in phases of differing pressure
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 800; c++) begin
                aw_push        = ($urandom_range(0, 3) < (ph == 1 ? 3 : 1));
                aw_master      = $urandom_range(0, 1);
                M_AXI_bvalid   = ($urandom_range(0, 3) < (ph == 2 ? 3 : 2));
                M_AXI_bresp    = 2'($urandom_range(0, 3));
                S00_AXI_bready = ($urandom_range(0, 3) < (ph == 3 ? 1 : 3));
                S01_AXI_bready = ($urandom_range(0, 3) < (ph == 3 ? 2 : 3));
                ARESET         = ($urandom_range(0, 299) == 0);
                tick();
            end
        end
        ARESET = 0; aw_push = 0; M_AXI_bvalid = 0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
